// File: rtl/contador_regressivo_pkg.sv
// Shared types and constants for the countdown counter and its button filter.
// Holds the FSM encoding, the count width and the 7-segment pattern table.
package contador_regressivo_pkg;

  localparam int LARGURA = 3;

  typedef logic [LARGURA-1:0] contagem_t;

  typedef enum logic [1:0] {
    OCIOSO   = 2'b00,
    CONTANDO = 2'b01,
    FIM      = 2'b10
  } estado_t;

  // abcdefg patterns, active-high, indexed by the count (entry 7 is leftmost)
  localparam logic [7:0][6:0] SEGMENTOS = {
    7'b1110000,  // 7
    7'b1011111,  // 6
    7'b1011011,  // 5
    7'b0110011,  // 4
    7'b1111001,  // 3
    7'b1101101,  // 2
    7'b0110000,  // 1
    7'b1111110   // 0
  };

  // The display is active-low, so the pattern is inverted here once.
  function automatic logic [6:0] decodifica(input contagem_t valor);
    return ~SEGMENTOS[valor];
  endfunction

endpackage

// File: rtl/filtro_botao.sv
// Push-button conditioner: 2-FF synchronizer, debounce filter and a one-cycle
// pulse on each debounced press (filtered 1->0). Reusable by other blocks.
module filtro_botao #(
  parameter int DEBOUNCE_CICLOS = 500000
) (
  input  logic clock_entrada,
  input  logic reset,
  input  logic botao,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CICLOS + 1);

  logic          sync1;
  logic          sync2;
  logic          filtrado;
  logic          armado;
  logic [1:0]    valido;
  logic [CW-1:0] estavel;
  logic          aceita;

  assign aceita = (sync2 != filtrado) && (estavel == CW'(DEBOUNCE_CICLOS - 1));

  // NOTE: sequential state uses <= so every register samples the pre-edge
  // values; blocking assignments here would chain sync1 into sync2 in one edge.
  always_ff @(posedge clock_entrada or posedge reset) begin
    if (reset) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      filtrado <= 1'b1;
      armado   <= 1'b0;
      valido   <= '0;
      estavel  <= '0;
      press    <= 1'b0;
    end else begin
      sync1  <= botao;
      sync2  <= sync1;
      valido <= {valido[0], 1'b1};
      // A press only counts once the button has really been seen released
      // after reset; the synchronizer's reset value does not qualify.
      if (valido[1] && sync2)
        armado <= 1'b1;
      press <= aceita && filtrado && armado;
      if (sync2 == filtrado)
        estavel <= '0;
      else if (aceita) begin
        filtrado <= sync2;
        estavel  <= '0;
      end else
        estavel <= estavel + CW'(1);
    end
  end

endmodule

// File: rtl/contador_regressivo.sv
// Countdown 7->0 at one step per DIV cycles after a debounced press, then
// holds fim until the next press. Outputs are registered 7-segment drives.
module contador_regressivo
  import contador_regressivo_pkg::*;
#(
  parameter int DIV             = 50000000,
  parameter int DEBOUNCE_CICLOS = 500000,
  parameter int VALOR_INICIAL   = 7
) (
  input  logic clock_entrada,
  input  logic reset,
  input  logic botao,
  output logic a,
  output logic b,
  output logic c,
  output logic d,
  output logic e,
  output logic f,
  output logic g,
  output logic ativo,
  output logic fim
);

  localparam int        PW    = $clog2(DIV);
  localparam contagem_t CARGA = contagem_t'(VALOR_INICIAL);

  estado_t       estado;
  estado_t       proximo;
  contagem_t     contagem;
  logic [PW-1:0] prescaler;
  logic          press;
  logic          tick;
  logic          ativo_d;
  logic          fim_d;
  logic [6:0]    seg_d;
  logic [6:0]    seg;

  filtro_botao #(
    .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)
  ) u_filtro (
    .clock_entrada(clock_entrada),
    .reset        (reset),
    .botao        (botao),
    .press        (press)
  );

  assign tick = (estado == CONTANDO) && (prescaler == PW'(DIV - 1));

  always_ff @(posedge clock_entrada or posedge reset) begin
    if (reset) estado <= OCIOSO;
    else       estado <= proximo;
  end

  // NOTE: proximo gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    proximo = estado;
    case (estado)
      OCIOSO:   if (press) proximo = CONTANDO;
      CONTANDO: if (!press && tick && contagem == '0) proximo = FIM;
      FIM:      if (press) proximo = CONTANDO;
      default:  proximo = OCIOSO;
    endcase
  end

  // Press has priority over tick: a restart always reloads and clears.
  always_ff @(posedge clock_entrada or posedge reset) begin
    if (reset) begin
      contagem  <= CARGA;
      prescaler <= '0;
    end else if (press) begin
      contagem  <= CARGA;
      prescaler <= '0;
    end else if (estado == CONTANDO) begin
      if (tick) begin
        prescaler <= '0;
        if (contagem != '0)
          contagem <= contagem - contagem_t'(1);
      end else
        prescaler <= prescaler + PW'(1);
    end else
      prescaler <= '0;
  end

  always_comb begin
    ativo_d = (estado == CONTANDO);
    fim_d   = (estado == FIM);
    seg_d   = decodifica(contagem);
  end

  always_ff @(posedge clock_entrada or posedge reset) begin
    if (reset) begin
      ativo <= 1'b0;
      fim   <= 1'b0;
      seg   <= decodifica(CARGA);
    end else begin
      ativo <= ativo_d;
      fim   <= fim_d;
      seg   <= seg_d;
    end
  end

  assign {a, b, c, d, e, f, g} = seg;

endmodule

// File: tb/tb_contador_regressivo.sv
// Bench for contador_regressivo: directed table, hand-aligned corner cases and
// random button traffic, all checked every cycle against a timestamp model.
module tb_contador_regressivo;

  localparam int DIV = 10;
  localparam int DEB = 4;
  localparam int VI  = 7;
  localparam int RUN = DIV * (VI + 1);

  localparam logic [6:0] SEG_TAB [8] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000
  };

  logic clock_entrada = 1'b0;
  logic reset;
  logic botao;
  logic a, b, c, d, e, f, g;
  logic ativo, fim;

  always #5 clock_entrada = ~clock_entrada;

  contador_regressivo #(
    .DIV(DIV), .DEBOUNCE_CICLOS(DEB), .VALOR_INICIAL(VI)
  ) dut (
    .clock_entrada(clock_entrada), .reset(reset), .botao(botao),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g),
    .ativo(ativo), .fim(fim)
  );

  int checks = 0;
  int falhas = 0;

  // Model: raw samples per edge since reset release, debounced level, and
  // the edges at which a press pulse is expected.
  bit hist[$];
  int presses[$];
  int n;
  bit filt;
  int primeiro_um;
  int press_model = 0;
  int press_dut   = 0;

  typedef struct {
    bit    nivel;
    int    ciclos;
    bit    ativo;
    bit    fim;
    int    valor;
    string nome;
  } vetor_t;

  vetor_t tabela [9];

  task automatic check(input string nome, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      falhas++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nome, got, exp, $time);
    end
  endtask

  task automatic check_saida(input string nome, input bit at, input bit fi, input int v);
    check(nome, {23'd0, ativo, fim, a, b, c, d, e, f, g}, {23'd0, at, fi, ~SEG_TAB[v]});
  endtask

  function automatic bit raw_at(input int i);
    if (i < 0) return 1'b1;
    return hist[i];
  endfunction

  // Outputs after edge m reflect a press pulse at edge p only if p <= m-2.
  function automatic void esperado(input int m, output bit at, output bit fi, output int v);
    int p;
    int k;
    p = -1;
    foreach (presses[i]) if (presses[i] <= m - 2) p = presses[i];
    at = 1'b0; fi = 1'b0; v = VI;
    if (p >= 0) begin
      k = m - p - 2;
      if (k < RUN) begin
        at = 1'b1;
        v  = VI - k / DIV;
      end else begin
        fi = 1'b1;
        v  = 0;
      end
    end
  endfunction

  task automatic modelo_reset();
    hist.delete();
    presses.delete();
    n           = 0;
    filt        = 1'b1;
    primeiro_um = -1;
  endtask

  task automatic passo();
    bit todos_dif;
    bit at, fi;
    int v;
    @(posedge clock_entrada);
    hist.push_back(botao);
    if (botao && primeiro_um < 0) primeiro_um = n;
    todos_dif = 1'b1;
    for (int i = n - 1 - DEB; i <= n - 2; i++)
      if (raw_at(i) == filt) todos_dif = 1'b0;
    if (todos_dif) begin
      if (filt && primeiro_um >= 0 && primeiro_um <= n - 3) begin
        presses.push_back(n);
        press_model++;
      end
      filt = !filt;
    end
    #1;
    if (dut.u_filtro.press) press_dut++;
    esperado(n, at, fi, v);
    check_saida("modelo", at, fi, v);
    n++;
  endtask

  task automatic ciclos(input bit nivel, input int quantos);
    botao = nivel;
    for (int i = 0; i < quantos; i++) passo();
  endtask

  // Reset asserted between edges; outputs must clear before the next edge.
  task automatic aplica_reset();
    #3;
    reset = 1'b1;
    #1;
    check_saida("reset_imediato", 1'b0, 1'b0, VI);
    repeat (3) @(posedge clock_entrada);
    #1;
    check_saida("reset_mantido", 1'b0, 1'b0, VI);
    reset = 1'b0;
    modelo_reset();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    int dd;
    int len;

    reset = 1'b1;
    botao = 1'b1;
    modelo_reset();
    repeat (3) @(posedge clock_entrada);
    #1;
    check_saida("reset_inicial", 1'b0, 1'b0, VI);
    reset = 1'b0;

    // Idle then one full run; press pulse at edge 55, outputs live from 57.
    tabela[0] = '{1'b1,  50, 1'b0, 1'b0, 7, "ocioso"};
    tabela[1] = '{1'b0,   7, 1'b0, 1'b0, 7, "antes_press"};
    tabela[2] = '{1'b0,   1, 1'b1, 1'b0, 7, "ativo_sobe"};
    tabela[3] = '{1'b0,   2, 1'b1, 1'b0, 7, "botao_segurado"};
    tabela[4] = '{1'b1,   7, 1'b1, 1'b0, 7, "ultimo_7"};
    tabela[5] = '{1'b1,   1, 1'b1, 1'b0, 6, "primeiro_6"};
    tabela[6] = '{1'b1,  69, 1'b1, 1'b0, 0, "ultimo_0"};
    tabela[7] = '{1'b1,   1, 1'b0, 1'b1, 0, "fim_sobe"};
    tabela[8] = '{1'b1, 100, 1'b0, 1'b1, 0, "fim_mantido"};
    for (int i = 0; i < 9; i++) begin
      ciclos(tabela[i].nivel, tabela[i].ciclos);
      check_saida(tabela[i].nome, tabela[i].ativo, tabela[i].fim, tabela[i].valor);
    end
    check("press_unico", press_dut, 1);

    // Bounce rejection from a fresh reset, then a clean press.
    aplica_reset();
    base = press_dut;
    ciclos(1'b1, 10);
    for (int i = 0; i < 5; i++) begin
      ciclos(1'b0, 2);
      ciclos(1'b1, 2);
    end
    ciclos(1'b1, 10);
    check("sem_press_ressalto", press_dut - base, 0);
    check_saida("ocioso_ressalto", 1'b0, 1'b0, VI);
    dd = n;
    ciclos(1'b0, 5);
    check("press_nao_antes", press_dut - base, 0);
    ciclos(1'b0, 1);
    check("press_apos_6", press_dut - base, 1);

    // Restart colliding with the 3->2 tick: pulse at dd+55, FSM sees it with tick.
    ciclos(1'b1, 44);
    ciclos(1'b0, 6);
    ciclos(1'b1, 1);
    check_saida("antes_colisao", 1'b1, 1'b0, 3);
    ciclos(1'b1, 1);
    check_saida("colisao_recarga", 1'b1, 1'b0, 7);
    ciclos(1'b1, 9);
    check_saida("colisao_7_mantido", 1'b1, 1'b0, 7);
    ciclos(1'b1, 1);
    check_saida("colisao_6", 1'b1, 1'b0, 6);
    ciclos(1'b1, (dd + 137) - n);
    check_saida("colisao_ultimo_0", 1'b1, 1'b0, 0);
    ciclos(1'b1, 1);
    check_saida("colisao_fim", 1'b0, 1'b1, 0);

    // Restart from FIM and a second complete run.
    ciclos(1'b0, 6);
    ciclos(1'b1, 1);
    check_saida("fim_ainda", 1'b0, 1'b1, 0);
    ciclos(1'b1, 1);
    check_saida("reinicio_de_fim", 1'b1, 1'b0, 7);
    ciclos(1'b1, RUN - 1);
    check_saida("segunda_volta_0", 1'b1, 1'b0, 0);
    ciclos(1'b1, 1);
    check_saida("segunda_volta_fim", 1'b0, 1'b1, 0);

    // Async reset at count 4 with the button held low through release.
    ciclos(1'b0, 6);
    ciclos(1'b1, 35);
    check_saida("contagem_4", 1'b1, 1'b0, 4);
    botao = 1'b0;
    aplica_reset();
    base = press_dut;
    ciclos(1'b0, 30);
    check("sem_press_pos_reset", press_dut - base, 0);
    ciclos(1'b1, 10);
    ciclos(1'b0, 6);
    check("press_apos_soltar", press_dut - base, 1);

    // Random button traffic against the model.
    for (int i = 0; i < 300; i++) begin
      len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(20, 120))
                                        : int'($urandom_range(1, 7));
      ciclos(1'($urandom_range(0, 1)), len);
    end
    check("contagem_press", press_dut, press_model);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, falhas);
    $finish;
  end

endmodule
